// File: rtl/calculator_pkg.sv
// Shared types and widths for the calculator input conditioning stage.
// Imported by the interface, the synchronizer and the top.
package calculator_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Operand and function-select widths.
    localparam int OP_W   = 8;
    localparam int FUNC_W = 3;
    localparam int CNT_W  = 8;

    // Raw input bundle: button, func, num1, num2.
    localparam int IN_W = 1 + FUNC_W + 2 * OP_W;

    // Pack raw switch/button inputs into one synchronizer word.
    function automatic logic [IN_W-1:0] pack_inputs(
        input logic              button,
        input logic [FUNC_W-1:0] func,
        input logic [OP_W-1:0]   num1,
        input logic [OP_W-1:0]   num2
    );
        return {button, func, num1, num2};
    endfunction

endpackage

// File: rtl/calculator_input_if.sv
// Raw switch/button inputs and conditioned outputs of calculator_input.
// master drives the raw inputs, slave is the conditioning stage.
interface calculator_input_if;
    import calculator_pkg::*;

    logic              button;
    logic [FUNC_W-1:0] func;
    logic [OP_W-1:0]   num1;
    logic [OP_W-1:0]   num2;

    logic              button_new;
    logic              button_level;
    logic [FUNC_W-1:0] func_q;
    logic [OP_W-1:0]   num1_q;
    logic [OP_W-1:0]   num2_q;
    logic [CNT_W-1:0]  press_cnt;
    logic              busy;

    modport master (
        output button, func, num1, num2,
        input  button_new, button_level,
        input  func_q, num1_q, num2_q,
        input  press_cnt, busy
    );

    modport slave (
        input  button, func, num1, num2,
        output button_new, button_level,
        output func_q, num1_q, num2_q,
        output press_cnt, busy
    );

endinterface

// File: rtl/bit_sync.sv
// Multi-bit flop-chain synchronizer, synchronous active-low reset.
// Every bit is sampled independently; callers handle coherence.
module bit_sync #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("bit_sync: DEPTH must be at least 2");
    end

    logic [W-1:0] stg [DEPTH];

    // Shift the raw word through DEPTH flops; reset clears the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/calculator_input.sv
// Synchronizes and debounces the push-button, freezes operands per press.
// Emits one button_new pulse for each accepted press.
module calculator_input
    import calculator_pkg::*;
#(
    parameter int CNT_MAX     = 200000,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    calculator_input_if.slave bus
);

    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    if (CNT_MAX < 2) begin : g_bad_cnt
        $error("calculator_input: CNT_MAX must be at least 2");
    end

    logic [IN_W-1:0]   raw;
    logic [IN_W-1:0]   synced;
    logic              b_s;
    logic [FUNC_W-1:0] func_s;
    logic [OP_W-1:0]   num1_s;
    logic [OP_W-1:0]   num2_s;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              pulse;
    logic              level;
    logic              busy_r;
    logic [FUNC_W-1:0] func_r;
    logic [OP_W-1:0]   num1_r;
    logic [OP_W-1:0]   num2_r;
    logic [CNT_W-1:0]  presses;

    assign raw = pack_inputs(bus.button, bus.func, bus.num1, bus.num2);

    bit_sync #(
        .W     (IN_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (synced)
    );

    assign {b_s, func_s, num1_s, num2_s} = synced;

    // Debounce FSM with counter, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse   <= 1'b0;
            level   <= 1'b0;
            busy_r  <= 1'b0;
            func_r  <= '0;
            num1_r  <= '0;
            num2_r  <= '0;
            presses <= '0;
        end else begin
            pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (b_s) begin
                        state  <= PRESS_WAIT;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!b_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= PRESSED;
                        pulse   <= 1'b1;
                        level   <= 1'b1;
                        func_r  <= func_s;
                        num1_r  <= num1_s;
                        num2_r  <= num2_s;
                        presses <= presses + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!b_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (b_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE;
                        level  <= 1'b0;
                        busy_r <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    level  <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.button_new   = pulse;
    assign bus.button_level = level;
    assign bus.busy         = busy_r;
    assign bus.func_q       = func_r;
    assign bus.num1_q       = num1_r;
    assign bus.num2_q       = num2_r;
    assign bus.press_cnt    = presses;

endmodule

// File: tb/tb_calculator_input.sv
// Directed bench for calculator_input with CNT_MAX=4, SYNC_STAGES=2.
// One task per scenario; expected values are hand-computed.
module tb_calculator_input;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   pulses;

    calculator_input_if bus();

    calculator_input #(
        .CNT_MAX     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses away from the rising edge.
    always @(negedge clk) begin
        if (bus.button_new === 1'b1) pulses++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.button = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        int early;
        early = 0;
        rst = 1'b0;
        bus.button = 1'b1;
        bus.func = 3'd5;
        bus.num1 = 8'h11;
        bus.num2 = 8'h22;
        tick(3);
        n_cmp++;
        if ({bus.button_new, bus.button_level, bus.busy, bus.press_cnt,
             bus.func_q, bus.num1_q, bus.num2_q} !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got new=%b lvl=%b busy=%b cnt=%h f=%h n1=%h n2=%h want all 0",
                     bus.button_new, bus.button_level, bus.busy, bus.press_cnt,
                     bus.func_q, bus.num1_q, bus.num2_q);
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.button_new !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL reset_early_pulse: got %0d early pulses want 0", early);
        end
        tick(1);
        n_cmp++;
        if (bus.button_new !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_pulse: got %b want 1", bus.button_new);
        end
        n_cmp++;
        if ({bus.func_q, bus.num1_q, bus.num2_q, bus.press_cnt} !== {3'd5, 8'h11, 8'h22, 8'd1}) begin
            n_bad++;
            $display("FAIL reset_capture: got f=%h n1=%h n2=%h cnt=%h want 5 11 22 01",
                     bus.func_q, bus.num1_q, bus.num2_q, bus.press_cnt);
        end
        bus.button = 1'b0;
        tick(12);
    endtask

    task automatic test_clean_press();
        int early;
        early = 0;
        do_reset();
        bus.num1 = 8'h3A;
        bus.num2 = 8'hC5;
        bus.func = 3'd2;
        tick(4);
        bus.button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.button_new !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL clean_early_pulse: got %0d want 0", early);
        end
        tick(1);
        n_cmp++;
        if (bus.button_new !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_pulse: got %b want 1", bus.button_new);
        end
        n_cmp++;
        if ({bus.func_q, bus.num1_q, bus.num2_q, bus.press_cnt} !== {3'd2, 8'h3A, 8'hC5, 8'd1}) begin
            n_bad++;
            $display("FAIL clean_capture: got f=%h n1=%h n2=%h cnt=%h want 2 3a c5 01",
                     bus.func_q, bus.num1_q, bus.num2_q, bus.press_cnt);
        end
        n_cmp++;
        if ({bus.button_level, bus.busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL clean_level_busy: got %b%b want 11", bus.button_level, bus.busy);
        end
        tick(1);
        n_cmp++;
        if (bus.button_new !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_single_cycle: got %b want 0", bus.button_new);
        end
    endtask

    task automatic test_operand_hold();
        int   p0;
        int   lvl_drop;
        logic seen;
        lvl_drop = 0;
        bus.num1 = 8'hFF;
        tick(10);
        n_cmp++;
        if (bus.num1_q !== 8'h3A) begin
            n_bad++;
            $display("FAIL hold_num1: got %h want 3a", bus.num1_q);
        end
        bus.button = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.button_level !== 1'b1) lvl_drop++;
        end
        tick(1);
        n_cmp++;
        if (lvl_drop !== 0 || bus.button_level !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL release_latency: got early_drops=%0d lvl=%b busy=%b want 0 0 0",
                     lvl_drop, bus.button_level, bus.busy);
        end
        tick(3);
        p0 = pulses;
        bus.button = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (bus.button_new === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1 || bus.num1_q !== 8'hFF || bus.press_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL second_press: got seen=%b n1=%h cnt=%h want 1 ff 02",
                     seen, bus.num1_q, bus.press_cnt);
        end
        bus.button = 1'b0;
        tick(12);
        n_cmp++;
        if (pulses - p0 !== 1) begin
            n_bad++;
            $display("FAIL second_press_count: got %0d pulses want 1", pulses - p0);
        end
    endtask

    task automatic test_press_bounce();
        int p0;
        int early;
        int lvl_drop;
        early = 0;
        lvl_drop = 0;
        p0 = pulses;
        bus.button = 1'b1; tick(1);
        bus.button = 1'b0; tick(1);
        bus.button = 1'b1; tick(1);
        bus.button = 1'b0; tick(1);
        bus.button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus.button_new !== 1'b0) early++;
        end
        tick(1);
        n_cmp++;
        if (early !== 0 || bus.button_new !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_pulse: got early=%0d new=%b want 0 1", early, bus.button_new);
        end
        tick(4);
        for (int g = 0; g < 2; g++) begin
            bus.button = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                if (bus.button_level !== 1'b1) lvl_drop++;
            end
            bus.button = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick(1);
                if (bus.button_level !== 1'b1) lvl_drop++;
            end
        end
        n_cmp++;
        if (lvl_drop !== 0) begin
            n_bad++;
            $display("FAIL release_bounce_level: got %0d drops want 0", lvl_drop);
        end
        bus.button = 1'b0;
        tick(12);
        n_cmp++;
        if (pulses - p0 !== 1 || bus.button_level !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_total: got pulses=%0d lvl=%b want 1 0",
                     pulses - p0, bus.button_level);
        end
    endtask

    task automatic test_short_glitch();
        int   p0;
        logic [7:0] n1;
        logic [7:0] pc;
        p0 = pulses;
        n1 = bus.num1_q;
        pc = bus.press_cnt;
        bus.num1 = 8'h55;
        tick(3);
        bus.button = 1'b1;
        tick(3);
        bus.button = 1'b0;
        tick(12);
        n_cmp++;
        if (pulses - p0 !== 0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_pulse: got pulses=%0d busy=%b want 0 0", pulses - p0, bus.busy);
        end
        n_cmp++;
        if (bus.num1_q !== n1 || bus.press_cnt !== pc) begin
            n_bad++;
            $display("FAIL glitch_capture: got n1=%h cnt=%h want %h %h", bus.num1_q, bus.press_cnt, n1, pc);
        end
    endtask

    task automatic test_reset_mid_count();
        int p0;
        p0 = pulses;
        bus.button = 1'b1;
        tick(4);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midcount_busy: got %b want 1", bus.busy);
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        bus.button = 1'b0;
        tick(12);
        n_cmp++;
        if (pulses - p0 !== 0 || bus.press_cnt !== 8'd0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midcount_abort: got pulses=%0d cnt=%h busy=%b want 0 00 0",
                     pulses - p0, bus.press_cnt, bus.busy);
        end
    endtask

    task automatic test_wrap();
        int   p0;
        logic last_seen;
        p0 = pulses;
        last_seen = 1'b0;
        for (int k = 0; k < 256; k++) begin
            bus.button = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick(1);
                if (k == 255 && bus.button_new === 1'b1) last_seen = 1'b1;
            end
            if (k == 254) begin
                n_cmp++;
                if (bus.press_cnt !== 8'd255) begin
                    n_bad++;
                    $display("FAIL wrap_255: got %h want ff", bus.press_cnt);
                end
            end
            bus.button = 1'b0;
            tick(10);
        end
        n_cmp++;
        if (bus.press_cnt !== 8'd0 || last_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_zero: got cnt=%h last_pulse=%b want 00 1", bus.press_cnt, last_seen);
        end
        n_cmp++;
        if (pulses - p0 !== 256) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d pulses want 256", pulses - p0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pulses = 0;
        rst = 1'b0;
        bus.button = 1'b0;
        bus.func = '0;
        bus.num1 = '0;
        bus.num2 = '0;
        tick(1);
        test_reset();
        test_clean_press();
        test_operand_hold();
        test_press_bounce();
        test_short_glitch();
        test_reset_mid_count();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
